str2mm_acq: RTL
===============

# str2mm_acq

Triggered, multi-channel stream-to-memory capture buffer, the successor of the single-channel capture buffer. It records DN channels of DW-bit samples into a circular buffer of DL samples per channel. Capture supports pre-trigger and post-trigger lengths, a free-run single-shot mode, and status reporting. The stored data is exposed read-only on the system bus. It sits between the acquisition stream (ADC/filter chain) and the processor bus, with both in one clock domain.

## Interface
Parameters:
- DW, 16, sample width in bits; legal values are 8, 16 and 32.
- DN, 2, number of channels; each stream beat carries one sample per channel.
- DL, 1<<14, depth in samples per channel; must be a power of two and at least 32/DW.
- AW, $clog2(DL), derived sample-pointer width; not to be overridden.

Ports:
- clk  in  1  system clock; also drives str and bus.
- rstn  in  1  asynchronous, active-low reset.
- ctl_rst  in  1  synchronous soft reset; forces IDLE and clears the pointer.
- ctl_start  in  1  single-cycle pulse that starts an acquisition.
- ctl_stop  in  1  single-cycle pulse that forces DONE.
- trg  in  1  trigger qualifier, sampled only on accepted beats.
- cfg_mode  in  1  selects the capture mode: 0 = triggered, 1 = free-run single shot.
- cfg_pre  in  AW  number of pre-trigger samples.
- cfg_post  in  AW  number of post-trigger samples.
- sts_run  out  1  high while the state is ARM, WAIT or POST.
- sts_done  out  1  high in DONE.
- sts_trg  out  1  set when a trigger was accepted during the current acquisition.
- sts_ptr  out  AW  sample index of the trigger beat, or of the last written beat if no trigger.
- str  axi4_stream_if.d  DN*DW bits  sample input; channel c is in TDATA[DW*c+:DW].
- bus  sys_bus_if.s  32 bits  read-only window onto the buffer.

## Operation
- TREADY is constant 1. A beat is accepted when TVALID=1, and it is written only in ARM, WAIT or POST. TLAST is ignored.
- Storage and pointer:
  - Channel c, sample n is stored at the pointer value wp at the time of its beat.
  - wp is AW bits wide and wraps from DL-1 to 0.
  - ctl_start clears wp to 0.
- cfg_mode, cfg_pre and cfg_post are registered on ctl_start and held constant for the whole acquisition.
- State machine transitions:
  - IDLE → ARM on ctl_start.
  - ARM → WAIT after cfg_pre beats have been written. If cfg_pre=0, the machine enters WAIT on the cycle after start.
  - WAIT → POST on an accepted beat with trg=1. That beat is written, sts_ptr is set to its wp, and sts_trg is set to 1. Triggers arriving in ARM are ignored.
  - POST → DONE once cfg_post further beats have been written. If cfg_post=0, DONE follows the trigger beat.
  - Free-run mode (cfg_mode=1): ARM → DONE after DL beats. trg is ignored, and sts_ptr = DL-1.
  - DONE → ARM on ctl_start, which re-arms and clears sts_trg. Any state → IDLE on ctl_rst.
- ctl_stop in ARM, WAIT or POST moves the machine to DONE on the next cycle. sts_ptr then holds the last written wp, and sts_trg is unchanged.
- Event priority: ctl_rst > ctl_stop > ctl_start. ctl_start is ignored in ARM, WAIT and POST.
- The caller guarantees cfg_pre + cfg_post ≤ DL-1. If the sum exceeds this, the oldest samples are overwritten; this is not flagged.
- Bus address map:
  - SPW = 32/DW samples per word.
  - bus.addr[2+:$clog2(DL/SPW)] is the word index w. The next $clog2(DN) bits select the channel.
  - The word contains samples w*SPW + k in bits [DW*k+:DW].
  - A channel index ≥ DN reads 0.
- Bus writes are acknowledged and have no effect. bus.err is always 0.
- Reads during capture are allowed and return the current RAM contents. There is no read/write collision guarantee for the same address in the same cycle.

## Timing
- Reset values:
  - State is IDLE; wp = 0.
  - sts_run, sts_done, sts_trg and sts_ptr are all 0.
  - bus.ack and bus.err are 0; bus.rdata is 0.
- The status outputs are registered and reflect an event one cycle after the clock edge that accepted it.
- Read latency: bus.ren in cycle t produces bus.ack=1 and valid bus.rdata in cycle t+2, because RAM output and data are registered. bus.wen in cycle t produces bus.ack in cycle t+1.
- Throughput is one beat per clock, sustained with no gaps.

## Structure
- A package str2mm_pkg holds:
  - the state enum (IDLE, ARM, WAIT, POST, DONE);
  - the mode constants;
  - a function computing SPW.
- Sub-module str2mm_bank: a single-channel RAM of SPW sub-banks, each of depth DL/SPW. It has a write port on sample index (sub-bank = n % SPW) and a 32-bit word read port. The top level instantiates DN of these banks.

## Test plan
1. Triggered capture, DW=16, DN=2, cfg_pre=4, cfg_post=3, ramp data (ch0 = n, ch1 = ~n), trg at beat 10 → DONE after beat 13. sts_ptr=10, sts_trg=1. Reading ch0 word 5 returns 0x000B000A.
2. trg pulsed at beat 2 (still in ARM) and again at beat 6 → only beat 6 is accepted; sts_ptr=6.
3. Free-run mode, DL=32, DW=8 → DONE after exactly 32 beats. Reading ch1 word 0 returns bytes {~3,~2,~1,~0}; sts_ptr=31.
4. Wrap: DL=16, cfg_pre=2, cfg_post=5, trigger at beat 20 → writes wrap through address 0. sts_ptr=4, and RAM[9] holds sample 25.
5. ctl_stop in WAIT after 7 beats → DONE one cycle later; sts_trg=0, sts_ptr=6. ctl_rst and ctl_start in the same cycle → IDLE.
6. rstn asserted in POST → all outputs take their reset values immediately. A bus read issued after release acks 2 cycles later with bus.err=0.

Source files
------------

// File: rtl/str2mm_pkg.sv
// str2mm_pkg: shared state, mode and sizing definitions for the capture buffer
package str2mm_pkg;
    typedef enum logic [2:0] {IDLE, ARM, WAIT, POST, DONE} state_t;
    localparam logic MODE_TRG  = 1'b0;
    localparam logic MODE_FREE = 1'b1;
    function automatic int spw(input int dw);
        return 32 / dw;
    endfunction
endpackage

// File: rtl/str2mm_if.sv
// str2mm_if: sample stream and system bus interfaces used by the capture buffer
interface axi4_stream_if #(parameter int W = 32);
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [W-1:0] tdata;
    modport d (input tvalid, tlast, tdata, output tready);
    modport s (output tvalid, tlast, tdata, input tready);
endinterface

interface sys_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wen;
    logic        ren;
    logic        ack;
    logic        err;
    modport s (input addr, wdata, wen, ren, output rdata, ack, err);
    modport m (output addr, wdata, wen, ren, input rdata, ack, err);
endinterface

// File: rtl/str2mm_bank.sv
// str2mm_bank: one channel of sample RAM split into SPW sub-banks behind a 32-bit word read port
module str2mm_bank
    import str2mm_pkg::*;
#(
    parameter int DW = 16,
    parameter int DL = 1 << 14,
    parameter int AW = $clog2(DL),
    localparam int RW = (DL / spw(DW) > 1) ? $clog2(DL / spw(DW)) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr,
    output logic [31:0]   rdata
);
    localparam int SPW   = spw(DW);
    localparam int DEPTH = DL / SPW;

    logic [RW-1:0] wrow;

    assign wrow = RW'(32'(waddr) / SPW);

    // sample n lands in sub-bank n % SPW so one word read returns SPW consecutive samples
    for (genvar k = 0; k < SPW; k++) begin : g_sub
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] q;
        always_ff @(posedge clk) begin
            if (we && (32'(waddr) % SPW) == k) mem[wrow] <= wdata;
            q <= mem[raddr];
        end
        assign rdata[DW*k +: DW] = q;
    end
endmodule

// File: rtl/str2mm_acq.sv
// str2mm_acq: triggered multi-channel stream-to-memory capture buffer with a read-only bus window
module str2mm_acq
    import str2mm_pkg::*;
#(
    parameter int DW = 16,
    parameter int DN = 2,
    parameter int DL = 1 << 14,
    parameter int AW = $clog2(DL)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ctl_rst,
    input  logic          ctl_start,
    input  logic          ctl_stop,
    input  logic          trg,
    input  logic          cfg_mode,
    input  logic [AW-1:0] cfg_pre,
    input  logic [AW-1:0] cfg_post,
    output logic          sts_run,
    output logic          sts_done,
    output logic          sts_trg,
    output logic [AW-1:0] sts_ptr,
    axi4_stream_if.d      str,
    sys_bus_if.s          bus
);
    localparam int SPW = spw(DW);
    localparam int WB  = $clog2(DL / SPW);
    localparam int RW  = WB > 0 ? WB : 1;
    localparam int CW  = $clog2(DN);
    localparam int CWI = CW > 0 ? CW : 1;

    state_t         st, nxt;
    logic [AW-1:0]  wp, lw, cnt, pre_q, post_q;
    logic           mode_q, run, wr, hit, stop;
    logic [RW-1:0]  raddr;
    logic [31:0]    ch;
    logic [CWI-1:0] ch_q;
    logic           ch_ok_q, ren_q;
    logic [31:0]    bank_rd [DN];
    logic           unused;

    assign run  = st == ARM || st == WAIT || st == POST;
    assign wr   = run && str.tvalid && !ctl_rst;
    assign stop = run && ctl_stop && !ctl_rst;
    assign hit  = st == WAIT && wr && trg && !ctl_stop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else st <= nxt;
    end

    always_comb begin
        nxt = st;
        if (ctl_rst) nxt = IDLE;
        else if (stop) nxt = DONE;
        else begin
            case (st)
                IDLE, DONE: nxt = ctl_start ? ARM : st;
                ARM: begin
                    if (mode_q == MODE_FREE) nxt = (wr && cnt == AW'(DL - 1)) ? DONE : ARM;
                    else nxt = (pre_q == '0 || (wr && cnt == pre_q - 1'b1)) ? WAIT : ARM;
                end
                WAIT: nxt = hit ? (post_q == '0 ? DONE : POST) : WAIT;
                POST: nxt = (wr && cnt == post_q - 1'b1) ? DONE : POST;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        sts_run  = run;
        sts_done = st == DONE;
    end

    // cnt counts pre-trigger writes in ARM and is restarted by the trigger beat for the post phase
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp      <= '0;
            lw      <= '0;
            cnt     <= '0;
            pre_q   <= '0;
            post_q  <= '0;
            mode_q  <= MODE_TRG;
            sts_trg <= 1'b0;
            sts_ptr <= '0;
        end else if (ctl_rst) begin
            wp <= '0;
        end else if (!run && ctl_start) begin
            wp      <= '0;
            lw      <= '0;
            cnt     <= '0;
            mode_q  <= cfg_mode;
            pre_q   <= cfg_pre;
            post_q  <= cfg_post;
            sts_trg <= 1'b0;
        end else begin
            if (wr) begin
                wp  <= wp + 1'b1;
                lw  <= wp;
                cnt <= hit ? '0 : cnt + 1'b1;
            end
            if (hit) sts_trg <= 1'b1;
            if (stop) sts_ptr <= wr ? wp : lw;
            else if (hit || (st == ARM && mode_q == MODE_FREE && nxt == DONE)) sts_ptr <= wp;
        end
    end

    assign ch    = 32'(bus.addr[31:2] >> WB) & ((32'd1 << CW) - 32'd1);
    assign raddr = WB > 0 ? RW'(bus.addr[31:2]) : '0;

    for (genvar c = 0; c < DN; c++) begin : g_ch
        str2mm_bank #(.DW(DW), .DL(DL), .AW(AW)) u_bank (
            .clk   (clk),
            .we    (wr),
            .waddr (wp),
            .wdata (str.tdata[DW*c +: DW]),
            .raddr (raddr),
            .rdata (bank_rd[c])
        );
    end

    // channel select travels alongside the RAM read so both line up in the second stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ren_q     <= 1'b0;
            ch_q      <= '0;
            ch_ok_q   <= 1'b0;
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            ren_q     <= bus.ren;
            ch_q      <= CWI'(ch);
            ch_ok_q   <= ch < DN;
            bus.ack   <= ren_q || bus.wen;
            bus.rdata <= (ren_q && ch_ok_q) ? bank_rd[ch_q] : '0;
        end
    end

    assign bus.err    = 1'b0;
    assign str.tready = 1'b1;
    assign unused     = ^{bus.addr, bus.wdata, str.tlast};
endmodule
